// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: tracks EX/MA/WB destination tags, selects operand
// forwarding, and drives stall/flush/memory-wait controls for a 5-stage core.
module pipe_hazard_unit #(
  parameter int REG_IDX_W = 5,
  parameter int NUM_READ  = 2,
  parameter int MEM_WAIT  = 2,
  parameter int ZERO_REG  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [NUM_READ*REG_IDX_W-1:0] id_src_idx,
  input  logic [NUM_READ-1:0]           id_src_used,
  input  logic [REG_IDX_W-1:0]          id_dst_idx,
  input  logic                          id_dst_wr,
  input  logic                          id_is_load,
  input  logic                          id_mem_op,
  input  logic                          ex_branch_taken,
  output logic [2*NUM_READ-1:0]         fwd_sel,
  output logic                          stall_if,
  output logic                          stall_id,
  output logic                          flush_if_id,
  output logic                          flush_id_ex,
  output logic                          mem_busy
);

  localparam int CNT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] dst;
    logic                 wr;
    logic                 load;
    logic                 mem_op;
  } tag_t;

  tag_t             ex_q, ma_q, wb_q;
  tag_t             ex_d, ma_d, wb_d;
  tag_t             id_tag;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             branch_flush;

  // A stage tag supplies a register only if it really writes it; the
  // hardwired zero register never produces a dependency.
  function automatic logic tag_hit(input tag_t t, input logic [REG_IDX_W-1:0] idx);
    return t.valid && t.wr && (t.dst == idx) && !((ZERO_REG != 0) && (idx == '0));
  endfunction

  assign id_tag       = '{valid: id_valid, dst: id_dst_idx, wr: id_dst_wr,
                          load: id_is_load, mem_op: id_mem_op};
  assign mem_busy     = (cnt_q != '0);
  assign branch_flush = ex_branch_taken && ex_q.valid;

  always_comb begin
    load_use = 1'b0;
    for (int k = 0; k < NUM_READ; k++) begin
      if (id_valid && id_src_used[k] && ex_q.load &&
          tag_hit(ex_q, id_src_idx[k*REG_IDX_W +: REG_IDX_W]))
        load_use = 1'b1;
    end
  end

  // Youngest producer wins; a load still in EX has no data to forward yet.
  always_comb begin
    fwd_sel = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      if (id_src_used[k]) begin
        if (tag_hit(ex_q, id_src_idx[k*REG_IDX_W +: REG_IDX_W]) && !ex_q.load)
          fwd_sel[2*k +: 2] = 2'd1;
        else if (tag_hit(ma_q, id_src_idx[k*REG_IDX_W +: REG_IDX_W]))
          fwd_sel[2*k +: 2] = 2'd2;
        else if (tag_hit(wb_q, id_src_idx[k*REG_IDX_W +: REG_IDX_W]))
          fwd_sel[2*k +: 2] = 2'd3;
      end
    end
  end

  // Priority: memory wait freezes everything, then taken branch, then load-use.
  always_comb begin
    ex_d        = ex_q;
    ma_d        = ma_q;
    wb_d        = wb_q;
    cnt_d       = cnt_q;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (mem_busy) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      cnt_d    = cnt_q - CNT_W'(1);
    end else begin
      wb_d = ma_q;
      ma_d = ex_q;
      ex_d = id_tag;
      if (ex_q.valid && ex_q.mem_op)
        cnt_d = CNT_W'(MEM_WAIT);
      if (branch_flush) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        ex_d        = '0;
      end else if (load_use) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        ex_d     = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      ma_q  <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      ma_q  <= ma_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
